// File: rtl/wav_dfi_lp_pkg.sv
// rtl/wav_dfi_lp_pkg.sv - shared types, counter widths and defaults for the DFI low-power responder
package wav_dfi_lp_pkg;

  localparam int TLP_RESP_DEF = 8;
  localparam int ACK_DLY_DEF  = 2;

  localparam int WAKE_CNT_W = 6;
  localparam int WIN_CNT_W  = 8;
  localparam int DLY_CNT_W  = 8;

  typedef enum logic [2:0] {
    LP_IDLE = 3'd0,
    LP_PEND = 3'd1,
    LP_ACK  = 3'd2,
    LP_WAKE = 3'd3,
    LP_DECL = 3'd4
  } lp_state_e;

endpackage

// File: rtl/wav_dfi_lp_chan.sv
// rtl/wav_dfi_lp_chan.sv - one DFI low-power channel: request FSM, response window and wakeup timer
module wav_dfi_lp_chan
  import wav_dfi_lp_pkg::*;
#(
  parameter int TLP_RESP = TLP_RESP_DEF,
  parameter int ACK_DLY  = ACK_DLY_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lp_allow,
  input  logic       init_start,
  input  logic       req,
  input  logic [5:0] wakeup,
  output logic       ack,
  output logic       lp_en,
  output logic       err
);

  if (ACK_DLY + 1 > TLP_RESP) begin : g_bad_window
    $error("wav_dfi_lp_chan: ACK_DLY+1 must not exceed TLP_RESP");
  end
  if (TLP_RESP > (1 << WIN_CNT_W) || ACK_DLY >= (1 << DLY_CNT_W)) begin : g_bad_width
    $error("wav_dfi_lp_chan: TLP_RESP/ACK_DLY exceed counter widths");
  end

  lp_state_e             state;
  logic [WIN_CNT_W-1:0]  win_cnt;
  logic [DLY_CNT_W-1:0]  dly_cnt;
  logic [WAKE_CNT_W-1:0] wake_cnt;
  logic [WAKE_CNT_W-1:0] code;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= LP_IDLE;
      win_cnt  <= '0;
      dly_cnt  <= '0;
      wake_cnt <= '0;
      code     <= '0;
      ack      <= 1'b0;
      lp_en    <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        LP_IDLE: begin
          if (req && !init_start) begin
            state   <= LP_PEND;
            dly_cnt <= DLY_CNT_W'(ACK_DLY);
            win_cnt <= '0;
          end
        end
        LP_PEND: begin
          win_cnt <= win_cnt + 1'b1;
          if (dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
          // A dropped request wins over an acknowledge decided on the same edge
          if (!req) begin
            state <= LP_IDLE;
          end else if (dly_cnt == '0 && lp_allow) begin
            state <= LP_ACK;
            code  <= wakeup;
            ack   <= 1'b1;
            lp_en <= 1'b1;
          end else if (win_cnt == WIN_CNT_W'(TLP_RESP - 1)) begin
            state <= LP_DECL;
          end
        end
        LP_ACK: begin
          if (req) begin
            code <= wakeup;
          end else begin
            state    <= LP_WAKE;
            wake_cnt <= code;
            lp_en    <= 1'b0;
          end
        end
        LP_WAKE: begin
          if (req) err <= 1'b1;
          if (wake_cnt == '0) begin
            state <= LP_IDLE;
            ack   <= 1'b0;
          end else begin
            wake_cnt <= wake_cnt - 1'b1;
          end
        end
        LP_DECL: begin
          if (!req) state <= LP_IDLE;
        end
        default: state <= LP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wav_dfi_lp_responder.sv
// rtl/wav_dfi_lp_responder.sv - DFI low-power responder top; data channel present only with WAV_DFI_LP_DATA_EN
module wav_dfi_lp_responder
  import wav_dfi_lp_pkg::*;
#(
  parameter int TLP_RESP = TLP_RESP_DEF,
  parameter int ACK_DLY  = ACK_DLY_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lp_allow,
  input  logic       init_start,
  input  logic       lp_ctrl_req,
  input  logic [5:0] lp_ctrl_wakeup,
  input  logic       lp_data_req,
  input  logic [5:0] lp_data_wakeup,
  output logic       lp_ctrl_ack,
  output logic       lp_data_ack,
  output logic       ctrl_lp_en,
  output logic       data_lp_en,
  output logic       lp_err
);

  logic ctrl_err;
  logic data_err;

  wav_dfi_lp_chan #(.TLP_RESP(TLP_RESP), .ACK_DLY(ACK_DLY)) u_ctrl (
    .clock      (clock),
    .reset      (reset),
    .lp_allow   (lp_allow),
    .init_start (init_start),
    .req        (lp_ctrl_req),
    .wakeup     (lp_ctrl_wakeup),
    .ack        (lp_ctrl_ack),
    .lp_en      (ctrl_lp_en),
    .err        (ctrl_err)
  );

`ifdef WAV_DFI_LP_DATA_EN
  wav_dfi_lp_chan #(.TLP_RESP(TLP_RESP), .ACK_DLY(ACK_DLY)) u_data (
    .clock      (clock),
    .reset      (reset),
    .lp_allow   (lp_allow),
    .init_start (init_start),
    .req        (lp_data_req),
    .wakeup     (lp_data_wakeup),
    .ack        (lp_data_ack),
    .lp_en      (data_lp_en),
    .err        (data_err)
  );
`else
  // Data ports stay on the interface so both builds share one pinout
  logic unused_data;
  assign unused_data = ^{lp_data_req, lp_data_wakeup};
  assign lp_data_ack = 1'b0;
  assign data_lp_en  = 1'b0;
  assign data_err    = 1'b0;
`endif

  assign lp_err = ctrl_err | data_err;

endmodule

// File: tb/tb_wav_dfi_lp_responder.sv
// tb/tb_wav_dfi_lp_responder.sv - self-checking bench for wav_dfi_lp_responder against a cycle model
module tb_wav_dfi_lp_responder;

  localparam int TLP = 8;
  localparam int AD  = 2;
`ifdef WAV_DFI_LP_DATA_EN
  localparam bit DATA_EN = 1'b1;
`else
  localparam bit DATA_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_WAIT = 1, M_GRANT = 2, M_TAIL = 3, M_REFUSE = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       lp_allow = 1'b0;
  logic       init_start = 1'b0;
  logic       lp_ctrl_req = 1'b0;
  logic [5:0] lp_ctrl_wakeup = '0;
  logic       lp_data_req = 1'b0;
  logic [5:0] lp_data_wakeup = '0;
  logic       lp_ctrl_ack, lp_data_ack, ctrl_lp_en, data_lp_en, lp_err;

  int n_tests = 0;
  int n_fail  = 0;

  int m_phase [2];
  int m_age   [2];
  int m_left  [2];
  int m_code  [2];
  bit m_err   [2];

  always #5 clock = ~clock;

  wav_dfi_lp_responder #(.TLP_RESP(TLP), .ACK_DLY(AD)) dut (
    .clock          (clock),
    .reset          (reset),
    .lp_allow       (lp_allow),
    .init_start     (init_start),
    .lp_ctrl_req    (lp_ctrl_req),
    .lp_ctrl_wakeup (lp_ctrl_wakeup),
    .lp_data_req    (lp_data_req),
    .lp_data_wakeup (lp_data_wakeup),
    .lp_ctrl_ack    (lp_ctrl_ack),
    .lp_data_ack    (lp_data_ack),
    .ctrl_lp_en     (ctrl_lp_en),
    .data_lp_en     (data_lp_en),
    .lp_err         (lp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_phase[c] = M_IDLE;
      m_age[c]   = 0;
      m_left[c]  = 0;
      m_code[c]  = 0;
      m_err[c]   = 1'b0;
    end
  endtask

  // m_age counts edges since the request was first accepted
  task automatic model_step(input int c, input bit req, input int wk);
    case (m_phase[c])
      M_IDLE: if (req && !init_start) begin
        m_phase[c] = M_WAIT;
        m_age[c]   = 0;
      end
      M_WAIT: begin
        m_age[c]++;
        if (!req) m_phase[c] = M_IDLE;
        else if (m_age[c] >= AD + 1 && lp_allow) begin
          m_phase[c] = M_GRANT;
          m_code[c]  = wk;
        end else if (m_age[c] >= TLP) m_phase[c] = M_REFUSE;
      end
      M_GRANT: if (req) m_code[c] = wk;
               else begin
                 m_phase[c] = M_TAIL;
                 m_left[c]  = m_code[c];
               end
      M_TAIL: begin
        if (req) m_err[c] = 1'b1;
        if (m_left[c] == 0) m_phase[c] = M_IDLE;
        else m_left[c]--;
      end
      default: if (!req) m_phase[c] = M_IDLE;
    endcase
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      if (!reset) model_reset();
      else begin
        model_step(0, lp_ctrl_req, int'(lp_ctrl_wakeup));
        if (DATA_EN) model_step(1, lp_data_req, int'(lp_data_wakeup));
      end
      #1;
      chk("ctrl_ack", {31'd0, lp_ctrl_ack}, {31'd0, m_phase[0] == M_GRANT || m_phase[0] == M_TAIL});
      chk("ctrl_lp_en", {31'd0, ctrl_lp_en}, {31'd0, m_phase[0] == M_GRANT});
      chk("data_ack", {31'd0, lp_data_ack}, {31'd0, m_phase[1] == M_GRANT || m_phase[1] == M_TAIL});
      chk("data_lp_en", {31'd0, data_lp_en}, {31'd0, m_phase[1] == M_GRANT});
      chk("lp_err", {31'd0, lp_err}, {31'd0, m_err[0] | m_err[1]});
    end
  endtask

  initial begin
    model_reset();
    tick(2);
    reset = 1'b1;
    tick(1);

    // accepted control request, wakeup 4
    lp_allow = 1'b1;
    lp_ctrl_wakeup = 6'd4;
    lp_ctrl_req = 1'b1;
    tick(5);
    lp_ctrl_req = 1'b0;
    tick(7);

    // decline on both channels with lp_allow low
    lp_allow = 1'b0;
    lp_ctrl_req = 1'b1;
    lp_data_req = 1'b1;
    tick(12);
    lp_allow = 1'b1;
    tick(2);
    lp_ctrl_req = 1'b0;
    lp_data_req = 1'b0;
    tick(1);
    lp_ctrl_req = 1'b1;
    tick(5);
    lp_ctrl_req = 1'b0;
    lp_ctrl_wakeup = 6'd0;
    tick(8);

    // abandoned request
    lp_ctrl_req = 1'b1;
    tick(1);
    lp_ctrl_req = 1'b0;
    tick(4);

    // init_start gating, then wakeup updated 2 -> 10 while acknowledged
    init_start = 1'b1;
    lp_ctrl_req = 1'b1;
    lp_ctrl_wakeup = 6'd2;
    tick(4);
    init_start = 1'b0;
    tick(5);
    lp_ctrl_wakeup = 6'd10;
    tick(2);
    lp_ctrl_req = 1'b0;
    tick(14);

    // re-request during wakeup sets the sticky error
    lp_ctrl_wakeup = 6'd6;
    lp_ctrl_req = 1'b1;
    tick(5);
    lp_ctrl_req = 1'b0;
    tick(3);
    lp_ctrl_req = 1'b1;
    tick(12);
    lp_ctrl_req = 1'b0;
    tick(10);

    // reset mid-ACK
    lp_ctrl_req = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    lp_ctrl_req = 1'b0;
    tick(3);

    // randomized traffic on both channels
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) lp_ctrl_req = ~lp_ctrl_req;
      if ($urandom_range(0, 5) == 0) lp_data_req = ~lp_data_req;
      lp_allow   = ($urandom_range(0, 3) != 0);
      init_start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) lp_ctrl_wakeup = 6'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) lp_data_wakeup = 6'($urandom_range(0, 9));
      reset = ($urandom_range(0, 399) != 0);
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
